// File: rtl/register_file.sv
// Architectural integer register file: two combinational read ports, one write port
// with optional write-first forwarding, and a per-register pending scoreboard.
module register_file #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [N-1:0]      rs1_data,
  output logic [N-1:0]      rs2_data,
  output logic              rs1_pending,
  output logic              rs2_pending,
  input  logic              wr_ena,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              reserve_ena,
  input  logic [ADDR_W-1:0] reserve_addr
);

  localparam int DEPTH      = 1 << ADDR_W;
  localparam bit USE_BYPASS = (BYPASS != 0);

  logic [N-1:0]     regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;

  // x0 has no storage; its constant slot keeps the read muxes uniform.
  assign regs_q[0] = '0;
  assign pend_q[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      logic [N-1:0] data_reg;
      logic         pend_reg;
      logic         wr_hit;
      logic         rsv_hit;

      assign wr_hit  = wr_ena && (wr_addr == ADDR_W'(gi));
      assign rsv_hit = reserve_ena && (reserve_addr == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_reg <= '0;
          pend_reg <= 1'b0;
        end else begin
          if (wr_hit)
            data_reg <= wr_data;
          // A reservation on the same edge as a write marks a newer producer, so it wins.
          if (rsv_hit)
            pend_reg <= 1'b1;
          else if (wr_hit)
            pend_reg <= 1'b0;
        end
      end

      assign regs_q[gi] = data_reg;
      assign pend_q[gi] = pend_reg;
    end
  endgenerate

  logic rs1_fwd;
  logic rs2_fwd;

  assign rs1_fwd = USE_BYPASS && wr_ena && (wr_addr == rs1_addr);
  assign rs2_fwd = USE_BYPASS && wr_ena && (wr_addr == rs2_addr);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != '0)
      rs1_data = rs1_fwd ? wr_data : regs_q[rs1_addr];
    if (rs2_addr != '0)
      rs2_data = rs2_fwd ? wr_data : regs_q[rs2_addr];
  end

  assign rs1_pending = pend_q[rs1_addr] && !rs1_fwd;
  assign rs2_pending = pend_q[rs2_addr] && !rs2_fwd;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: one forwarding and one non-forwarding instance share stimulus
// and are checked every cycle against an array-based model, plus literal expectations.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, reserve_addr;
  logic        wr_ena, reserve_ena;
  logic [31:0] wr_data;

  logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic        b_rs1_pend, b_rs2_pend, n_rs1_pend, n_rs2_pend;

  int checks = 0;
  int fails  = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  register_file #(.N(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_pending(b_rs1_pend), .rs2_pending(b_rs2_pend),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .reserve_ena(reserve_ena), .reserve_addr(reserve_addr)
  );

  register_file #(.N(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
    .rs1_pending(n_rs1_pend), .rs2_pending(n_rs2_pend),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .reserve_ena(reserve_ena), .reserve_addr(reserve_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state as plain arrays.
  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_ena && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (reserve_ena && reserve_addr != 0)
        m_pend[reserve_addr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr_ena && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_pend(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    return {31'h0, m_pend[a] && !(byp && wr_ena && wr_addr == a)};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byp_rs1_data", b_rs1_data, exp_data(rs1_addr, 1'b1));
      chk("byp_rs2_data", b_rs2_data, exp_data(rs2_addr, 1'b1));
      chk("byp_rs1_pend", {31'h0, b_rs1_pend}, exp_pend(rs1_addr, 1'b1));
      chk("byp_rs2_pend", {31'h0, b_rs2_pend}, exp_pend(rs2_addr, 1'b1));
      chk("nb_rs1_data", n_rs1_data, exp_data(rs1_addr, 1'b0));
      chk("nb_rs2_data", n_rs2_data, exp_data(rs2_addr, 1'b0));
      chk("nb_rs1_pend", {31'h0, n_rs1_pend}, exp_pend(rs1_addr, 1'b0));
      chk("nb_rs2_pend", {31'h0, n_rs2_pend}, exp_pend(rs2_addr, 1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_ena = 0; reserve_ena = 0; wr_addr = 0; reserve_addr = 0; wr_data = 0;
  endtask

  initial begin
    rst = 1'b0;
    rs1_addr = 0; rs2_addr = 0;
    idle();
    cmp_en = 1'b1;
    repeat (2) tick();
    rs1_addr = 5; rs2_addr = 31;
    #2;
    chk("reset_rs1", b_rs1_data, 32'h0);
    chk("reset_pend", {31'h0, b_rs2_pend}, 32'h0);
    tick();
    rst = 1'b1;

    // Write x5 then read on both ports
    wr_ena = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; rs2_addr = 5;
    @(negedge clk);
    chk("x5_fwd_same_cycle", b_rs1_data, 32'hDEADBEEF);
    chk("x5_nofwd_same_cycle", n_rs1_data, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("x5_rs1", b_rs1_data, 32'hDEADBEEF);
    chk("x5_rs2", b_rs2_data, 32'hDEADBEEF);
    chk("x5_nb_rs2", n_rs2_data, 32'hDEADBEEF);

    // Forward check on x7
    tick();
    wr_ena = 1; wr_addr = 7; wr_data = 32'h12345678; rs1_addr = 7; rs2_addr = 0;
    @(negedge clk);
    chk("x7_bypass", b_rs1_data, 32'h12345678);
    chk("x7_no_bypass", n_rs1_data, 32'h0);

    // x0 ignores writes and reservations
    tick();
    wr_ena = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rs1_addr = 0; rs2_addr = 0;
    tick(); idle(); reserve_ena = 1; reserve_addr = 0;
    @(negedge clk);
    chk("x0_rs1", b_rs1_data, 32'h0);
    chk("x0_rs2", n_rs2_data, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("x0_pend", {31'h0, b_rs1_pend}, 32'h0);

    // Reserve x3, then satisfy it
    tick();
    reserve_ena = 1; reserve_addr = 3;
    tick(); idle(); rs2_addr = 3;
    @(negedge clk);
    chk("x3_pend_set", {31'h0, b_rs2_pend}, 32'h1);
    tick();
    wr_ena = 1; wr_addr = 3; wr_data = 32'h42;
    @(negedge clk);
    chk("x3_pend_fwd_drop", {31'h0, b_rs2_pend}, 32'h0);
    chk("x3_pend_nb_held", {31'h0, n_rs2_pend}, 32'h1);
    tick(); idle();
    @(negedge clk);
    chk("x3_pend_after", {31'h0, b_rs2_pend}, 32'h0);
    chk("x3_data", b_rs2_data, 32'h42);

    // Reserve and write x9 on the same edge
    tick();
    reserve_ena = 1; reserve_addr = 9; wr_ena = 1; wr_addr = 9; wr_data = 32'h55; rs1_addr = 9;
    tick(); idle();
    @(negedge clk);
    chk("x9_data", b_rs1_data, 32'h55);
    chk("x9_pend_wins", {31'h0, b_rs1_pend}, 32'h1);
    tick();
    wr_ena = 1; wr_addr = 9; wr_data = 32'h66;
    tick(); idle();
    @(negedge clk);
    chk("x9_pend_cleared", {31'h0, n_rs1_pend}, 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      tick();
      wr_ena       = ($urandom_range(0, 1) == 1);
      wr_addr      = 5'($urandom_range(0, 31));
      wr_data      = $urandom;
      reserve_ena  = ($urandom_range(0, 2) == 0);
      reserve_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rs1_addr     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rs2_addr     = ($urandom_range(0, 4) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
    end

    // Fill, reserve a few, then reset asynchronously mid-cycle
    for (int i = 1; i < 32; i++) begin
      tick();
      wr_ena = 1; wr_addr = 5'(i); wr_data = 32'hA5000000 | 32'(i * 17);
      reserve_ena = (i % 4 == 0); reserve_addr = 5'(i - 1);
    end
    tick(); idle();
    rs1_addr = 31; rs2_addr = 3;
    @(negedge clk);
    chk("fill_x31", b_rs1_data, 32'hA5000000 | 32'(31 * 17));
    chk("fill_x3_pend", {31'h0, b_rs2_pend}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #0.1;
      chk("rst_rs1_data", b_rs1_data, 32'h0);
      chk("rst_rs2_data", n_rs2_data, 32'h0);
      chk("rst_rs1_pend", {31'h0, b_rs1_pend}, 32'h0);
      chk("rst_rs2_pend", {31'h0, n_rs2_pend}, 32'h0);
    end
    tick();
    rst = 1'b1;
    rs1_addr = 31; rs2_addr = 31;
    @(negedge clk);
    chk("post_rst_x31", b_rs1_data, 32'h0);
    chk("post_rst_x31_nb", n_rs2_data, 32'h0);

    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
